pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Owns the program counter and drives instruction fetch for the multi-cycle CPU core.
//  Produces the next-PC candidates (PC+4, branch, jump, JR) and selects one using the same 2-bit pc_sel/zero encoding the datapath's PC selector consumes.
//  Fetches from instruction memory over a req/ack handshake and hands each instruction to decode over a valid/ready handshake.
//  Halts on the HALT opcode.
// PARAMETERS
//  RESET_PC     32'h0000_0000  PC loaded on reset; must be word aligned
//  HALT_OPCODE  6'b111111      instr[31:26] value that stops fetch
// PORTS
//  clk          in   1   single clock, all state on rising edge
//  reset        in   1   synchronous, active-high
//  imem_req     out  1   fetch request, held until imem_ack
//  imem_addr    out  32  fetch address (= current PC), stable while imem_req=1
//  imem_ack     in   1   imem_data valid this cycle
//  imem_data    in   32  fetched instruction word
//  instr_valid  out  1   instr/instr_pc hold a valid instruction
//  instr        out  32  instruction to decode
//  instr_pc     out  32  PC of instr
//  instr_ready  in   1   decode/execute retires instr this cycle
//  pc_sel       in   2   00 seq, 01 beq, 10 jump, 11 jr; sampled at retire
//  zero         in   1   ALU zero flag; sampled at retire
//  branch_off   in   32  sign-extended word offset; sampled at retire
//  jump_target  in   26  instr[25:0] jump field; sampled at retire
//  jr_addr      in   32  register jump address; sampled at retire
//  halted       out  1   sticky halt indicator
// BEHAVIOUR
//  Reset (clk edge with reset=1): pc<=RESET_PC, state<=FETCH, imem_req=0, instr_valid=0, instr=0, instr_pc=0, halted=0.
//   imem_req rises the first cycle after reset deasserts.
//   Reset has priority over every other event.
//   Reset mid-fetch or mid-issue abandons the transaction.
//  FSM:
//   FETCH: imem_req=1, imem_addr=pc.
//    On imem_ack: latch instr<=imem_data and instr_pc<=pc, then -> ISSUE.
//   ISSUE: instr_valid=1; instr and instr_pc are held stable until retire.
//    On instr_ready: pc<=next_pc. If instr[31:26]==HALT_OPCODE -> HALT, else -> FETCH.
//   HALT: imem_req=0, instr_valid=0, halted=1. Only reset leaves HALT.
//  imem_ack is ignored outside FETCH. instr_ready is ignored outside ISSUE.
//  Latency and throughput:
//   ack in cycle N -> instr_valid=1 in N+1.
//   Retire in cycle M -> imem_req=1 with the new address in M+1.
//   Minimum 2 cycles per instruction (ack in the first FETCH cycle).
//  next_pc (pc4 = pc+4, all arithmetic mod 2^32, wrap silently):
//   00: pc4
//   01: zero ? pc4 + (branch_off<<2) : pc4
//   10: {pc4[31:28], jump_target, 2'b00}
//   11: {jr_addr[31:2], 2'b00}  (misaligned low bits dropped)
//  The HALT instruction still updates pc through next_pc, so instr_pc debug stays consistent.
//  PC 32'hFFFF_FFFC + 4 wraps to 0. Offset 0xFFFF_FFFF branches to PC (pc4-4).
// STRUCTURE
//  Shared package cpu_pkg holds:
//   PC_SEL_SEQ/BEQ/JUMP/JR 2-bit constants
//   HALT_OPCODE default
//   fetch state encoding FETCH/ISSUE/HALT
//  Sub-module next_pc_calc (combinational): pc, pc_sel, zero, branch_off, jump_target, jr_addr -> next_pc.
//  Top level holds the FSM, pc register and the instr/instr_pc registers.
// TESTING
//  reset, imem acks 1 cycle after req, instr_ready=1, pc_sel=00 ->
//   imem_addr 0,4,8,...; one instr_valid every 2 cycles.
//  pc=0x10, pc_sel=01, zero=1, branch_off=0xFFFF_FFFE -> next fetch 0x0C;
//   same stimulus with zero=0 -> next fetch 0x14.
//  pc=0x4000_0010, pc_sel=10, jump_target=0x000_0040 -> next fetch 0x4000_0100;
//   pc_sel=11, jr_addr=0x0000_0203 -> next fetch 0x200.
//  imem_ack delayed 5 cycles, then instr_ready held 0 for 3 cycles ->
//   imem_addr and instr stable throughout; spurious ack in ISSUE ignored.
//  instr=0xFC00_0000 retired -> halted=1, imem_req=0 forever;
//   reset -> fetch restarts at RESET_PC.
//  reset asserted while imem_req=1 -> next cycle imem_req=0, instr_valid=0, pc=RESET_PC;
//   pc=0xFFFF_FFFC with seq -> wraps to 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the CPU core: PC selector codes, halt opcode and fetch FSM states.
package cpu_pkg;

    localparam logic [1:0] PC_SEL_SEQ  = 2'b00;
    localparam logic [1:0] PC_SEL_BEQ  = 2'b01;
    localparam logic [1:0] PC_SEL_JUMP = 2'b10;
    localparam logic [1:0] PC_SEL_JR   = 2'b11;

    localparam logic [5:0] HALT_OPCODE_DEFAULT = 6'b111111;

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        ISSUE = 2'b01,
        HALT  = 2'b10
    } fetch_state_e;

    function automatic logic is_opcode(input logic [31:0] word, input logic [5:0] opcode);
        return (word[31:26] == opcode);
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, conditional branch, jump and register jump.
module next_pc_calc
    import cpu_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [1:0]  pc_sel_i,
    input  logic        zero_i,
    input  logic [31:0] branch_off_i,
    input  logic [25:0] jump_target_i,
    input  logic [31:0] jr_addr_i,
    output logic [31:0] next_pc_o
);

    logic [31:0] pc4_s;

    // Candidate generation and selection; all sums wrap modulo 2^32.
    always_comb begin
        pc4_s     = pc_i + 32'd4;
        next_pc_o = pc4_s;
        case (pc_sel_i)
            PC_SEL_SEQ: next_pc_o = pc4_s;
            PC_SEL_BEQ: begin
                if (zero_i) begin
                    next_pc_o = pc4_s + {branch_off_i[29:0], 2'b00};
                end else begin
                    next_pc_o = pc4_s;
                end
            end
            PC_SEL_JUMP: next_pc_o = {pc4_s[31:28], jump_target_i, 2'b00};
            PC_SEL_JR:   next_pc_o = {jr_addr_i[31:2], 2'b00};
            default:     next_pc_o = pc4_s;
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter owner and fetch FSM: imem req/ack on one side, decode valid/ready on the other.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic [1:0]  pc_sel,
    input  logic        zero,
    input  logic [31:0] branch_off,
    input  logic [25:0] jump_target,
    input  logic [31:0] jr_addr,
    output logic        halted
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  instr_pc_q, instr_pc_d;
    logic         req_q, req_d;
    logic         valid_q, valid_d;
    logic         halted_q, halted_d;
    logic [31:0]  next_pc_s;

    next_pc_calc u_next_pc_calc (
        .pc_i          (pc_q),
        .pc_sel_i      (pc_sel),
        .zero_i        (zero),
        .branch_off_i  (branch_off),
        .jump_target_i (jump_target),
        .jr_addr_i     (jr_addr),
        .next_pc_o     (next_pc_s)
    );

    // Next-state logic; outputs are decoded from the next state so they come straight off flops.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        case (state_q)
            FETCH: begin
                // req_q gates the ack so the cycle right after reset cannot capture a stray ack.
                if (req_q && imem_ack) begin
                    instr_d    = imem_data;
                    instr_pc_d = pc_q;
                    state_d    = ISSUE;
                end else begin
                    state_d    = FETCH;
                end
            end
            ISSUE: begin
                if (instr_ready) begin
                    pc_d    = next_pc_s;
                    state_d = is_opcode(instr_q, HALT_OPCODE) ? HALT : FETCH;
                end else begin
                    state_d = ISSUE;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
        req_d    = (state_d == FETCH);
        valid_d  = (state_d == ISSUE);
        halted_d = (state_d == HALT);
    end

    // State, PC and instruction registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0000_0000;
            instr_pc_q <= 32'h0000_0000;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
            halted_q   <= halted_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit; inputs driven and outputs sampled on the falling edge.
module tb_pc_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic [1:0]  pc_sel;
    logic        zero;
    logic [31:0] branch_off;
    logic [25:0] jump_target;
    logic [31:0] jr_addr;
    logic        halted;

    int          tests_run;
    int          tests_failed;
    logic [31:0] held_instr;

    pc_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .pc_sel      (pc_sel),
        .zero        (zero),
        .branch_off  (branch_off),
        .jump_target (jump_target),
        .jr_addr     (jr_addr),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Wait `delay` cycles with req held, then ack with `data`; checks the issue that follows.
    task automatic fetch_instr(input logic [31:0] exp_addr, input logic [31:0] data, input int delay);
        for (int i = 0; i < delay; i++) begin
            check_eq("wait_req", {31'd0, imem_req}, 32'd1);
            check_eq("wait_addr", imem_addr, exp_addr);
            @(negedge clk);
        end
        check_eq("fetch_req", {31'd0, imem_req}, 32'd1);
        check_eq("fetch_addr", imem_addr, exp_addr);
        check_eq("fetch_valid_low", {31'd0, instr_valid}, 32'd0);
        imem_ack  = 1'b1;
        imem_data = data;
        @(negedge clk);
        imem_ack  = 1'b0;
        imem_data = 32'hDEAD_BEEF;
        held_instr = data;
        check_eq("issue_valid", {31'd0, instr_valid}, 32'd1);
        check_eq("issue_req_low", {31'd0, imem_req}, 32'd0);
        check_eq("issue_instr", instr, data);
        check_eq("issue_instr_pc", instr_pc, exp_addr);
    endtask

    // Stall `stall` cycles (optionally with a spurious ack), then retire with the given selector inputs.
    task automatic retire(input logic [1:0] sel, input logic z, input logic [31:0] off,
                          input logic [25:0] jt, input logic [31:0] jr, input int stall,
                          input logic spurious, input logic [31:0] exp_pc);
        for (int i = 0; i < stall; i++) begin
            instr_ready = 1'b0;
            imem_ack    = spurious;
            imem_data   = 32'h1234_5678;
            @(negedge clk);
            imem_ack = 1'b0;
            check_eq("stall_valid", {31'd0, instr_valid}, 32'd1);
            check_eq("stall_instr", instr, held_instr);
            check_eq("stall_instr_pc", instr_pc, exp_pc);
            check_eq("stall_addr", imem_addr, exp_pc);
            check_eq("stall_req_low", {31'd0, imem_req}, 32'd0);
        end
        pc_sel      = sel;
        zero        = z;
        branch_off  = off;
        jump_target = jt;
        jr_addr     = jr;
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        pc_sel      = 2'b00;
        zero        = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        held_instr   = 32'h0;
        reset        = 1'b1;
        imem_ack     = 1'b0;
        imem_data    = 32'h0;
        instr_ready  = 1'b0;
        pc_sel       = 2'b00;
        zero         = 1'b0;
        branch_off   = 32'h0;
        jump_target  = 26'h0;
        jr_addr      = 32'h0;

        @(negedge clk);
        @(negedge clk);
        check_eq("rst_req", {31'd0, imem_req}, 32'd0);
        check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("rst_instr", instr, 32'h0);
        check_eq("rst_instr_pc", instr_pc, 32'h0);
        check_eq("rst_halted", {31'd0, halted}, 32'd0);
        check_eq("rst_addr", imem_addr, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Sequential stream 0,4,8 then a JR to 0x10.
        for (int k = 0; k < 3; k++) begin
            fetch_instr(32'(k * 4), 32'h2000_0000 + 32'(k), 0);
            retire(2'b00, 1'b0, 32'h0, 26'h0, 32'h0, 0, 1'b0, 32'(k * 4));
        end
        fetch_instr(32'h0000_000C, 32'h2000_0003, 0);
        retire(2'b11, 1'b0, 32'h0, 26'h0, 32'h0000_0010, 0, 1'b0, 32'h0000_000C);

        // Taken branch backwards: 0x14 + (-2<<2) = 0x0C.
        fetch_instr(32'h0000_0010, 32'h1000_FFFE, 0);
        retire(2'b01, 1'b1, 32'hFFFF_FFFE, 26'h0, 32'h0, 0, 1'b0, 32'h0000_0010);
        fetch_instr(32'h0000_000C, 32'h2000_0004, 0);
        retire(2'b11, 1'b0, 32'h0, 26'h0, 32'h0000_0010, 0, 1'b0, 32'h0000_000C);

        // Same branch not taken -> 0x14.
        fetch_instr(32'h0000_0010, 32'h1000_FFFE, 0);
        retire(2'b01, 1'b0, 32'hFFFF_FFFE, 26'h0, 32'h0, 0, 1'b0, 32'h0000_0010);

        // Offset -1 branches to own PC.
        fetch_instr(32'h0000_0014, 32'h1000_FFFF, 0);
        retire(2'b01, 1'b1, 32'hFFFF_FFFF, 26'h0, 32'h0, 0, 1'b0, 32'h0000_0014);
        fetch_instr(32'h0000_0014, 32'h2000_0005, 0);
        retire(2'b11, 1'b0, 32'h0, 26'h0, 32'h4000_0010, 0, 1'b0, 32'h0000_0014);

        // Jump keeps pc4 upper nibble: 0x4000_0100; then JR with misaligned 0x203 -> 0x200.
        fetch_instr(32'h4000_0010, 32'h0800_0040, 0);
        retire(2'b10, 1'b0, 32'h0, 26'h000_0040, 32'h0, 0, 1'b0, 32'h4000_0010);
        fetch_instr(32'h4000_0100, 32'h2000_0006, 0);
        retire(2'b11, 1'b0, 32'h0, 26'h0, 32'h0000_0203, 0, 1'b0, 32'h4000_0100);

        // Slow memory and stalled decode with a spurious ack during issue.
        fetch_instr(32'h0000_0200, 32'h8C00_0200, 5);
        retire(2'b11, 1'b0, 32'h0, 26'h0, 32'hFFFF_FFFF, 3, 1'b1, 32'h0000_0200);

        // PC wrap from 0xFFFF_FFFC to 0.
        fetch_instr(32'hFFFF_FFFC, 32'h2000_0007, 0);
        retire(2'b00, 1'b0, 32'h0, 26'h0, 32'h0, 0, 1'b0, 32'hFFFF_FFFC);
        fetch_instr(32'h0000_0000, 32'h2000_0008, 0);
        retire(2'b00, 1'b0, 32'h0, 26'h0, 32'h0, 0, 1'b0, 32'h0000_0000);

        // Reset while requesting address 4.
        check_eq("pre_rst_req", {31'd0, imem_req}, 32'd1);
        check_eq("pre_rst_addr", imem_addr, 32'h0000_0004);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("midrst_req", {31'd0, imem_req}, 32'd0);
        check_eq("midrst_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("midrst_addr", imem_addr, 32'h0);
        @(negedge clk);

        // HALT instruction: pc still advances, fetch stops, acks/readies ignored.
        fetch_instr(32'h0000_0000, 32'hFC00_0000, 0);
        retire(2'b00, 1'b0, 32'h0, 26'h0, 32'h0, 0, 1'b0, 32'h0000_0000);
        for (int i = 0; i < 4; i++) begin
            check_eq("halt_flag", {31'd0, halted}, 32'd1);
            check_eq("halt_req", {31'd0, imem_req}, 32'd0);
            check_eq("halt_valid", {31'd0, instr_valid}, 32'd0);
            check_eq("halt_addr", imem_addr, 32'h0000_0004);
            imem_ack    = 1'b1;
            instr_ready = 1'b1;
            @(negedge clk);
        end
        imem_ack    = 1'b0;
        instr_ready = 1'b0;

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("unhalt_flag", {31'd0, halted}, 32'd0);
        check_eq("unhalt_req_low", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        fetch_instr(32'h0000_0000, 32'h2000_0009, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
